// File: rtl/grf_scoreboard_if.sv
// D-stage read/write request and hazard-resolution results for the GRF scoreboard.
// The master side drives D-stage requests; the slave side returns stall and forward selects.
interface grf_scoreboard_if #(
  parameter int unsigned TW   = 2,
  parameter int unsigned CNTW = 32
);
  logic            d_valid;
  logic [4:0]      d_rs;
  logic [4:0]      d_rt;
  logic            d_rs_use;
  logic            d_rt_use;
  logic [TW-1:0]   d_tuse_rs;
  logic [TW-1:0]   d_tuse_rt;
  logic            d_we;
  logic [4:0]      d_a3;
  logic [TW-1:0]   d_tnew;
  logic            stall;
  logic [1:0]      fwd_rs;
  logic [1:0]      fwd_rt;
  logic [4:0]      e_busy_a3;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_tuse_rs, d_tuse_rt,
           d_we, d_a3, d_tnew,
    input  stall, fwd_rs, fwd_rt, e_busy_a3, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_tuse_rs, d_tuse_rt,
           d_we, d_a3, d_tnew,
    output stall, fwd_rs, fwd_rt, e_busy_a3, stall_cnt
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Tracks in-flight GRF writes in E/M/W and resolves D-stage stall and forward selects.
// stall and fwd_* are combinational on D inputs; entries and stall_cnt are registered.
module grf_scoreboard #(
  parameter int unsigned TW   = 2,
  parameter int unsigned CNTW = 32
) (
  input  logic             clk,
  input  logic             rst,
  grf_scoreboard_if.slave  sb
);

  localparam int unsigned AW = 5;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } entry_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd;
  } res_t;

  entry_t          r_e;
  entry_t          r_m;
  entry_t          r_w;
  logic [CNTW-1:0] r_stall_cnt;

  entry_t w_e_next;
  entry_t w_m_next;
  entry_t w_w_next;
  logic   w_writing;
  logic   w_stall;
  res_t   w_res_rs;
  res_t   w_res_rt;

  // Youngest match wins; only E/M producers with a late result can stall.
  function automatic res_t resolve(
    input entry_t        e,
    input entry_t        m,
    input entry_t        w,
    input logic [AW-1:0] r,
    input logic          use_r,
    input logic [TW-1:0] tuse,
    input logic          dv
  );
    res_t          res;
    logic          nz;
    logic          hit;
    logic          in_em;
    logic [TW-1:0] t;
    logic [1:0]    src;
    res   = '0;
    nz    = (r != '0);
    hit   = 1'b0;
    in_em = 1'b0;
    t     = '0;
    src   = FWD_GRF;
    if (nz && e.valid && (e.a3 == r)) begin
      hit   = 1'b1;
      in_em = 1'b1;
      t     = e.tnew;
      src   = FWD_E;
    end else if (nz && m.valid && (m.a3 == r)) begin
      hit   = 1'b1;
      in_em = 1'b1;
      t     = m.tnew;
      src   = FWD_M;
    end else if (nz && w.valid && (w.a3 == r)) begin
      hit   = 1'b1;
      t     = '0;
      src   = FWD_W;
    end
    res.stall = dv && use_r && in_em && (t > tuse);
    res.fwd   = (use_r && hit && (t == '0)) ? src : FWD_GRF;
    return res;
  endfunction

  always_comb begin
    w_res_rs = resolve(r_e, r_m, r_w, sb.d_rs, sb.d_rs_use, sb.d_tuse_rs, sb.d_valid);
    w_res_rt = resolve(r_e, r_m, r_w, sb.d_rt, sb.d_rt_use, sb.d_tuse_rt, sb.d_valid);
    w_stall  = w_res_rs.stall | w_res_rt.stall;
  end

  // Pipeline advance: W takes M with tnew cleared, M takes E aged by one, E takes D or a bubble.
  always_comb begin
    w_writing     = sb.d_valid && sb.d_we && (sb.d_a3 != '0);

    w_w_next       = '0;
    w_w_next.valid = r_m.valid;
    w_w_next.a3    = r_m.a3;

    w_m_next       = '0;
    w_m_next.valid = r_e.valid;
    w_m_next.a3    = r_e.a3;
    w_m_next.tnew  = (r_e.tnew == '0) ? '0 : (r_e.tnew - TW'(1));

    w_e_next = '0;
    if (!w_stall && w_writing) begin
      w_e_next.valid = 1'b1;
      w_e_next.a3    = sb.d_a3;
      w_e_next.tnew  = sb.d_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e         <= '0;
      r_m         <= '0;
      r_w         <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_e <= w_e_next;
      r_m <= w_m_next;
      r_w <= w_w_next;
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
    end
  end

  assign sb.stall     = w_stall;
  assign sb.fwd_rs    = w_res_rs.fwd;
  assign sb.fwd_rt    = w_res_rt.fwd;
  assign sb.e_busy_a3 = r_e.valid ? r_e.a3 : '0;
  assign sb.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard with hand-computed expectations.
module tb_grf_scoreboard;

  localparam int unsigned TW   = 2;
  localparam int unsigned CNTW = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  grf_scoreboard_if #(.TW(TW), .CNTW(CNTW)) sb_if ();

  grf_scoreboard #(.TW(TW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rs_use, input logic rt_use,
                       input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                       input logic we, input logic [4:0] a3, input logic [1:0] tnew);
    sb_if.d_valid   = v;
    sb_if.d_rs      = rs;
    sb_if.d_rt      = rt;
    sb_if.d_rs_use  = rs_use;
    sb_if.d_rt_use  = rt_use;
    sb_if.d_tuse_rs = tuse_rs;
    sb_if.d_tuse_rt = tuse_rt;
    sb_if.d_we      = we;
    sb_if.d_a3      = a3;
    sb_if.d_tnew    = tnew;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic issue_wr(input logic [4:0] a3, input logic [1:0] tnew);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, a3, tnew);
  endtask

  task automatic rd(input logic [4:0] rs, input logic [4:0] rt,
                    input logic rs_use, input logic rt_use,
                    input logic [1:0] tuse_rs, input logic [1:0] tuse_rt);
    drive(1'b1, rs, rt, rs_use, rt_use, tuse_rs, tuse_rt, 1'b0, 5'd0, 2'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    repeat (3) tick();
    chk("rst_stall", 32'(sb_if.stall), 32'd0);
    chk("rst_fwd_rs", 32'(sb_if.fwd_rs), 32'd0);
    chk("rst_fwd_rt", 32'(sb_if.fwd_rt), 32'd0);
    chk("rst_cnt", sb_if.stall_cnt, 32'd0);
    chk("rst_busy", 32'(sb_if.e_busy_a3), 32'd0);

    // Load-use: two stall cycles, then forward from W
    issue_wr(5'd8, 2'd2);
    chk("ld_issue_stall", 32'(sb_if.stall), 32'd0);
    tick();
    chk("ld_busy", 32'(sb_if.e_busy_a3), 32'd8);
    rd(5'd8, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0);
    chk("ld_stall1", 32'(sb_if.stall), 32'd1);
    tick();
    chk("ld_stall2", 32'(sb_if.stall), 32'd1);
    chk("ld_busy_bubble", 32'(sb_if.e_busy_a3), 32'd0);
    tick();
    chk("ld_stall_end", 32'(sb_if.stall), 32'd0);
    chk("ld_fwd_w", 32'(sb_if.fwd_rs), 32'd3);
    chk("ld_cnt", sb_if.stall_cnt, 32'd2);
    idle();
    tick();

    // ALU back-to-back: tuse=1 needs no forward yet, next read takes M
    issue_wr(5'd9, 2'd1);
    tick();
    rd(5'd0, 5'd9, 1'b0, 1'b1, 2'd0, 2'd1);
    chk("alu_stall", 32'(sb_if.stall), 32'd0);
    chk("alu_fwd_rt_e", 32'(sb_if.fwd_rt), 32'd0);
    tick();
    rd(5'd0, 5'd9, 1'b0, 1'b1, 2'd0, 2'd0);
    chk("alu_stall_m", 32'(sb_if.stall), 32'd0);
    chk("alu_fwd_rt_m", 32'(sb_if.fwd_rt), 32'd2);
    idle();
    tick();
    tick();

    // Two producers of $5: youngest (E) wins, then M once E drains
    issue_wr(5'd5, 2'd0);
    tick();
    issue_wr(5'd5, 2'd0);
    tick();
    rd(5'd5, 5'd5, 1'b1, 1'b1, 2'd0, 2'd0);
    chk("multi_fwd_rs", 32'(sb_if.fwd_rs), 32'd1);
    chk("multi_fwd_rt", 32'(sb_if.fwd_rt), 32'd1);
    chk("multi_stall", 32'(sb_if.stall), 32'd0);
    tick();
    chk("multi_fwd_rs_m", 32'(sb_if.fwd_rs), 32'd2);
    idle();
    tick();
    tick();

    // Ports resolve independently against different stages
    issue_wr(5'd3, 2'd0);
    tick();
    issue_wr(5'd4, 2'd0);
    tick();
    rd(5'd3, 5'd4, 1'b1, 1'b1, 2'd0, 2'd0);
    chk("pair_fwd_rs", 32'(sb_if.fwd_rs), 32'd2);
    chk("pair_fwd_rt", 32'(sb_if.fwd_rt), 32'd1);
    chk("pair_busy", 32'(sb_if.e_busy_a3), 32'd4);
    // Unused port never forwards
    rd(5'd3, 5'd4, 1'b0, 1'b1, 2'd0, 2'd0);
    chk("pair_unused_rs", 32'(sb_if.fwd_rs), 32'd0);
    idle();
    tick();
    tick();

    // Writes to $0 are never tracked
    issue_wr(5'd0, 2'd0);
    tick();
    chk("zero_busy", 32'(sb_if.e_busy_a3), 32'd0);
    rd(5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0);
    chk("zero_stall", 32'(sb_if.stall), 32'd0);
    chk("zero_fwd_rs", 32'(sb_if.fwd_rs), 32'd0);
    idle();
    tick();
    tick();

    // No stall without a valid D instruction
    issue_wr(5'd8, 2'd2);
    tick();
    drive(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("nvalid_stall", 32'(sb_if.stall), 32'd0);
    idle();
    repeat (3) tick();
    chk("nvalid_cnt", sb_if.stall_cnt, 32'd2);

    // Reset during a stall clears all entries and the counter
    issue_wr(5'd8, 2'd2);
    tick();
    rd(5'd8, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0);
    chk("mid_stall_pre", 32'(sb_if.stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_stall_post", 32'(sb_if.stall), 32'd0);
    chk("mid_busy", 32'(sb_if.e_busy_a3), 32'd0);
    chk("mid_cnt", sb_if.stall_cnt, 32'd0);
    tick();
    chk("mid_stall_m", 32'(sb_if.stall), 32'd0);
    tick();
    chk("mid_fwd_w", 32'(sb_if.fwd_rs), 32'd0);
    chk("mid_cnt_hold", sb_if.stall_cnt, 32'd0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Read-side companion to the general register file in the 5-stage MIPS pipeline (D, E, M, W).
- Tracks in-flight GRF writes in E, M and W, and decides whether the D-stage reader stalls.
- For each D-stage read port it selects the newest correct source: the GRF itself, or a forward from E, M or W.
- The GRF writes on the clock edge and has no internal bypass, so a same-cycle W write must be forwarded by this block.

Parameters:
- TW, 2, width of the Tnew/Tuse cycle counters.
- CNTW, 32, width of the stall-cycle statistic counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- d_valid  input  1  D stage holds a real instruction
- d_rs  input  5  D-stage read address 1 (GRF A1)
- d_rt  input  5  D-stage read address 2 (GRF A2)
- d_rs_use  input  1  D instruction reads rs
- d_rt_use  input  1  D instruction reads rt
- d_tuse_rs  input  TW  cycles until rs value is consumed (0=D, 1=E, 2=M)
- d_tuse_rt  input  TW  same, for rt
- d_we  input  1  D instruction will write the GRF
- d_a3  input  5  D instruction destination (future GRF A3)
- d_tnew  input  TW  cycles after entering E until the result exists (0..2)
- stall  output  1  freeze PC/F/D, insert bubble into E
- fwd_rs  output  2  0=GRF, 1=E, 2=M, 3=W
- fwd_rt  output  2  same encoding, for rt
- e_busy_a3  output  5  destination held in E entry (0 if invalid), for debug
- stall_cnt  output  CNTW  count of cycles in which stall was 1

Behaviour:
- State: three entries E, M, W, each holding {valid, a3[4:0], tnew[TW-1:0]}.
- Reset (rst=1 at posedge):
  - all valid=0, a3=0, tnew=0, stall_cnt=0.
  - With state cleared: stall=0, fwd_rs=fwd_rt=0, e_busy_a3=0 in the following cycle.
- Reset overrides all other inputs, including a stall in progress.
- Entry admission: D is "writing" iff d_valid & d_we & (d_a3 != 0). Writes to $0 are never tracked.
- Every posedge when not in reset:
  - W <= M, with tnew forced to 0.
  - M <= E, with tnew = (E.tnew==0) ? 0 : E.tnew-1.
  - If stall=0: E <= {writing, writing ? d_a3 : 0, writing ? d_tnew : 0}.
  - If stall=1: E <= bubble (valid=0, a3=0, tnew=0).
  - The previous W entry retires; the GRF performs that write on the same edge.
- Match definition: a match for read address r exists in stage X iff X.valid & X.a3==r & r!=0.
- Youngest-match priority is E, then M, then W. Only the youngest match is considered.
- Stall, per port p in {rs, rt}:
  - stall_p = d_valid & d_p_use & youngest match exists in E or M & match.tnew > d_tuse_p.
  - stall = stall_rs | stall_rt. Combinational from current state and D inputs.
- Forward select, per port:
  - fwd_p = code of the youngest matching stage if that stage's tnew==0, else 0.
  - fwd_p = 0 when there is no match, when p reads $0, or when the port is not used.
  - If the youngest match has tnew>0 and no stall is raised, fwd_p=0. Downstream-stage forwarding is out of scope for this block.
- stall_cnt increments by 1 on each posedge with stall=1 and rst=0. Wraps modulo 2^CNTW.
- Simultaneous events:
  - Both ports may match different stages; each is resolved independently.
  - If both ports match the same register, both outputs carry the same code.
  - A stall and a W retirement in the same cycle are legal; W still retires.
- A stalled D instruction re-evaluates each cycle as entries age. The stall ends in the first cycle where the youngest match has tnew <= tuse.
- Latency: outputs reflect the new state one cycle after the edge. stall and fwd are combinational on D inputs (zero-cycle).

Test Plan:
- Reset, then idle with d_valid=0 for 3 cycles -> stall=0, fwd_rs=fwd_rt=0, stall_cnt=0, e_busy_a3=0.
- Sequence with a load dependency:
  - Stimulus: D issues we=1, a3=8, tnew=2 (load); next cycle D reads rs=8, tuse_rs=0.
  - Required: stall=1 for exactly 2 cycles, then fwd_rs=3 (W) with stall=0; stall_cnt=2.
- ALU back-to-back:
  - Stimulus: a3=9, tnew=1; next cycle rt=9, tuse_rt=1.
  - Required: stall=0 and fwd_rt=0 in that cycle; the following dependent read with tuse=0 sees fwd_rt=2 (M).
- Multiple producers of one register:
  - Stimulus: a3=5 issued with tnew=0 twice in consecutive cycles; then read rs=5, tuse_rs=0.
  - Required: fwd_rs=1 (E, youngest), not 2.
- Zero register: we=1 with a3=0, then read rs=0 with tuse_rs=0 -> stall=0, fwd_rs=0, E entry invalid (e_busy_a3=0).
- Reset mid-operation:
  - Stimulus: during a stall (load a3=8, tnew=2, then rs=8, tuse_rs=0), assert rst for 1 cycle.
  - Required: next cycle stall=0, all entries invalid, stall_cnt=0.
